// File: rtl/mux_rr_arbiter_if.sv
// rtl/mux_rr_arbiter_if.sv - request/data/handshake bundle for the muxN round-robin arbiter
//
// Purpose: groups the requester side (req, din), the downstream
// valid/ready handshake (out_valid, out_ready, out_data) and the
// observability outputs (sel, gnt, busy) of mux_rr_arbiter.
//
// Modports:
//   master - the arbiter: takes req/din/out_ready and drives
//            out_valid/out_data/sel/gnt/busy
//   slave  - the environment around the arbiter (mirror of master)

interface mux_rr_arbiter_if #(
  parameter int N = 10,
  parameter int W = 5
);
  logic [N-1:0]   req;
  logic [N*W-1:0] din;
  logic           out_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [3:0]     sel;
  logic [N-1:0]   gnt;
  logic           busy;

  modport master (
    input  req, din, out_ready,
    output out_valid, out_data, sel, gnt, busy
  );

  modport slave (
    output req, din, out_ready,
    input  out_valid, out_data, sel, gnt, busy
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter driving the select of a 10-way muxN
//
// Purpose: picks one of N requesters per transfer in round-robin order,
// holds the registered select for the shared muxN and presents the
// selected word downstream over a valid/ready handshake. out_data is the
// raw muxN output for the registered select; there is no data register.
//
// Optional feature: define MUX_ARB_BURST_EN to let a grantee keep the
// grant for up to BURST_LEN consecutive transfers while its req stays high.
//
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - synchronous active-high reset
//   bus  - mux_rr_arbiter_if.master: req, din, out_ready in;
//          out_valid, out_data, sel, gnt, busy out

// 10-way W-bit multiplexer; selects outside 0..9 yield zero.
module muxN #(
  parameter int W = 5
) (
  input  logic [W-1:0] i0,
  input  logic [W-1:0] i1,
  input  logic [W-1:0] i2,
  input  logic [W-1:0] i3,
  input  logic [W-1:0] i4,
  input  logic [W-1:0] i5,
  input  logic [W-1:0] i6,
  input  logic [W-1:0] i7,
  input  logic [W-1:0] i8,
  input  logic [W-1:0] i9,
  input  logic [3:0]   sel,
  output logic [W-1:0] y
);
  always_comb begin
    case (sel)
      4'd0:    y = i0;
      4'd1:    y = i1;
      4'd2:    y = i2;
      4'd3:    y = i3;
      4'd4:    y = i4;
      4'd5:    y = i5;
      4'd6:    y = i6;
      4'd7:    y = i7;
      4'd8:    y = i8;
      4'd9:    y = i9;
      default: y = '0;
    endcase
  end
endmodule

module mux_rr_arbiter #(
  parameter int N = 10,
  parameter int W = 5
`ifdef MUX_ARB_BURST_EN
  , parameter int BURST_LEN = 4
`endif
) (
  input logic clk,
  input logic rst,
  mux_rr_arbiter_if.master bus
);
  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] LAST = 4'(N - 1);

  state_t       state;
  logic [3:0]   ptr;
  logic [3:0]   sel_q;
  logic [N-1:0] gnt_q;
  logic         valid_q;
  logic         busy_q;

  logic [3:0]   sel_inc;
  logic         transfer;
  logic         keep;
  logic         rotate;

  logic [3:0]   arb_base;
  logic [N-1:0] arb_req;
  logic         win_found;
  logic [3:0]   win_idx;
  int           scan_idx;

  assign sel_inc  = (sel_q == LAST) ? 4'd0 : sel_q + 4'd1;
  assign transfer = valid_q && bus.out_ready;

`ifdef MUX_ARB_BURST_EN
  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  logic [CW-1:0] cnt;

  // The grantee may keep the grant only while it still asks for it and
  // its burst budget has room for another transfer.
  assign keep = bus.req[sel_q] && (int'(cnt) < BURST_LEN - 1);
`else
  assign keep = 1'b0;
`endif

  assign rotate = transfer && !keep;

  // One scanner serves both cases: from IDLE it starts at ptr with the raw
  // requests; on a transfer it starts one past the grantee (the new ptr)
  // and ignores the grantee, whose request counts as consumed.
  always_comb begin
    arb_base = ptr;
    arb_req  = bus.req;
    if (state == GRANT) begin
      arb_base         = sel_inc;
      arb_req[sel_q]   = 1'b0;
    end
  end

  // Scan from the farthest offset down so the closest hit to arb_base wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 4'd0;
    scan_idx  = 0;
    for (int k = N - 1; k >= 0; k--) begin
      scan_idx = int'(arb_base) + k;
      if (scan_idx >= N) scan_idx = scan_idx - N;
      if (arb_req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = 4'(scan_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= 4'd0;
      sel_q   <= 4'd0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MUX_ARB_BURST_EN
      cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state   <= GRANT;
            sel_q   <= win_idx;
            gnt_q   <= {{(N-1){1'b0}}, 1'b1} << win_idx;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        GRANT: begin
`ifdef MUX_ARB_BURST_EN
          if (transfer) cnt <= keep ? cnt + 1'b1 : '0;
`endif
          // Without a transfer everything holds; request changes never
          // preempt the current grant.
          if (rotate) begin
            ptr <= sel_inc;
            if (win_found) begin
              sel_q <= win_idx;
              gnt_q <= {{(N-1){1'b0}}, 1'b1} << win_idx;
            end else begin
              state   <= IDLE;
              sel_q   <= 4'd0;
              gnt_q   <= '0;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sel       = sel_q;
  assign bus.gnt       = gnt_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = busy_q;

  muxN #(.W(W)) u_mux (
    .i0  (bus.din[0*W +: W]),
    .i1  (bus.din[1*W +: W]),
    .i2  (bus.din[2*W +: W]),
    .i3  (bus.din[3*W +: W]),
    .i4  (bus.din[4*W +: W]),
    .i5  (bus.din[5*W +: W]),
    .i6  (bus.din[6*W +: W]),
    .i7  (bus.din[7*W +: W]),
    .i8  (bus.din[8*W +: W]),
    .i9  (bus.din[9*W +: W]),
    .sel (sel_q),
    .y   (bus.out_data)
  );
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - self-checking bench for mux_rr_arbiter

module tb_mux_rr_arbiter;
  localparam int N = 10;
  localparam int W = 5;
`ifdef MUX_ARB_BURST_EN
  localparam int BL = 4;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_rr_arbiter_if #(.N(N), .W(W)) bus ();

  mux_rr_arbiter #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who holds the grant, where the rotation starts, and
  // how many extra transfers the current grantee has consumed.
  bit m_init  = 1'b0;
  bit m_valid = 1'b0;
  int m_sel   = 0;
  int m_ptr   = 0;
  int m_cnt   = 0;

  function automatic int pick(input int p, input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    logic [N-1:0] r;
    bit keep_m;
    int w;
    if (rst) begin
      m_init = 1'b1; m_valid = 1'b0; m_sel = 0; m_ptr = 0; m_cnt = 0;
    end else if (m_init) begin
      if (!m_valid) begin
        w = pick(m_ptr, bus.req);
        if (w >= 0) begin m_valid = 1'b1; m_sel = w; end
      end else if (bus.out_ready) begin
        keep_m = 1'b0;
`ifdef MUX_ARB_BURST_EN
        keep_m = bus.req[m_sel] && (m_cnt < BL - 1);
`endif
        if (keep_m) begin
          m_cnt = m_cnt + 1;
        end else begin
          m_cnt = 0;
          m_ptr = (m_sel + 1) % N;
          r = bus.req;
          r[m_sel] = 1'b0;
          w = pick(m_ptr, r);
          if (w >= 0) m_sel = w;
          else begin m_valid = 1'b0; m_sel = 0; end
        end
      end
    end
  end

  // Compare process: every falling edge once the model is anchored by reset.
  always @(negedge clk) begin
    if (m_init) begin
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("sel", 32'(bus.sel), 32'(m_sel));
      chk("gnt", 32'(bus.gnt), m_valid ? (32'd1 << m_sel) : 32'd0);
      chk("busy", 32'(bus.busy), 32'(m_valid));
      chk("out_data", 32'(bus.out_data), 32'(bus.din[m_sel*W +: W]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit r, input logic [N-1:0] q, input bit rdy);
    rst = r;
    bus.req = q;
    bus.out_ready = rdy;
  endtask

  task automatic put_slot(input int i, input logic [W-1:0] v);
    bus.din[i*W +: W] = v;
  endtask

  initial begin
    int exp3 [4];
    int exp6 [8];
    logic [N-1:0] rq;
`ifdef MUX_ARB_BURST_EN
    exp3 = '{0, 0, 0, 0};
    exp6 = '{5, 5, 5, 5, 6, 6, 6, 6};
`else
    exp3 = '{0, 1, 9, 0};
    exp6 = '{5, 6, 5, 6, 5, 6, 5, 6};
`endif
    for (int i = 0; i < N; i++) put_slot(i, W'($urandom));

    // Reset with every request high.
    set_in(1'b1, 10'h3FF, 1'b1);
    tick(); tick();
    chk("t1_valid", 32'(bus.out_valid), 32'd0);
    chk("t1_gnt", 32'(bus.gnt), 32'd0);
    chk("t1_sel", 32'(bus.sel), 32'd0);
    set_in(1'b0, 10'h3FF, 1'b1);
    tick();
    chk("t1_first_sel", 32'(bus.sel), 32'd0);
    chk("t1_first_valid", 32'(bus.out_valid), 32'd1);

    // Single requester.
    set_in(1'b1, '0, 1'b1); tick();
    put_slot(3, 5'b00010);
    set_in(1'b0, 10'h008, 1'b1); tick();
    chk("t2_sel", 32'(bus.sel), 32'd3);
    chk("t2_gnt", 32'(bus.gnt), 32'h008);
    chk("t2_data", 32'(bus.out_data), 32'b00010);
    chk("t2_valid", 32'(bus.out_valid), 32'd1);
    set_in(1'b0, '0, 1'b1); tick();
    chk("t2_idle", 32'(bus.out_valid), 32'd0);

    // Rotation across 0, 1, 9.
    set_in(1'b1, '0, 1'b1); tick();
    put_slot(0, 5'b10000); put_slot(1, 5'b10001); put_slot(9, 5'b01000);
    set_in(1'b0, 10'h203, 1'b1);
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("t3_sel", 32'(bus.sel), 32'(exp3[j]));
      chk("t3_valid", 32'(bus.out_valid), 32'd1);
    end

    // Backpressure holds the grant while req[0] toggles.
    set_in(1'b1, '0, 1'b1); tick();
    set_in(1'b0, 10'h006, 1'b0); tick();
    chk("t4_sel0", 32'(bus.sel), 32'd1);
    for (int j = 0; j < 3; j++) begin
      set_in(1'b0, (j % 2 == 0) ? 10'h007 : 10'h006, 1'b0);
      tick();
      chk("t4_sel", 32'(bus.sel), 32'd1);
      chk("t4_gnt", 32'(bus.gnt), 32'h002);
      chk("t4_valid", 32'(bus.out_valid), 32'd1);
    end
    set_in(1'b0, 10'h005, 1'b1); tick();
    chk("t4_next", 32'(bus.sel), 32'd2);

    // Wrap from ptr 9 to requester 2.
    set_in(1'b1, '0, 1'b1); tick();
    set_in(1'b0, 10'h100, 1'b1); tick();
    chk("t5_sel8", 32'(bus.sel), 32'd8);
    set_in(1'b0, 10'h204, 1'b1); tick();
    chk("t5_sel9", 32'(bus.sel), 32'd9);
    set_in(1'b0, 10'h004, 1'b1); tick();
    chk("t5_sel2", 32'(bus.sel), 32'd2);

    // Two persistent requesters: burst or strict alternation.
    set_in(1'b1, '0, 1'b1); tick();
    set_in(1'b0, 10'h060, 1'b1);
    for (int j = 0; j < 8; j++) begin
      tick();
      chk("t6_sel", 32'(bus.sel), 32'(exp6[j]));
    end

    // Randomized traffic with occasional reset.
    for (int c = 0; c < 3000; c++) begin
      rq = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom & $urandom);
      for (int i = 0; i < N; i++) put_slot(i, W'($urandom));
      set_in($urandom_range(0, 99) == 0, rq, $urandom_range(0, 3) != 0);
      tick();
    end

    set_in(1'b0, '0, 1'b1);
    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
